// File: rtl/sram_write_ctrl.sv
// SRAM write controller: stores admitted packets in a circular SRAM region,
// emits one descriptor per packet and tracks occupancy and dropped packets.
module sram_write_ctrl #(
  parameter int unsigned data_width    = 64,
  parameter int unsigned port_width    = 4,
  parameter int unsigned addr_width    = 10,
  parameter int unsigned max_pkt_words = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  in_vld,
  input  logic [data_width-1:0] in_data,
  input  logic [port_width-1:0] in_port,
  output logic                  in_rdy,
  output logic                  sram_we,
  output logic [addr_width-1:0] sram_addr,
  output logic [data_width-1:0] sram_wdata,
  output logic                  desc_vld,
  input  logic                  desc_rdy,
  output logic [addr_width-1:0] desc_start,
  output logic [addr_width:0]   desc_len,
  output logic [port_width-1:0] desc_port,
  output logic                  desc_err,
  output logic                  desc_drop,
  input  logic                  rel_vld,
  input  logic [addr_width:0]   rel_len,
  output logic [addr_width:0]   used_cnt,
  output logic [15:0]           drop_cnt
);

  typedef enum logic [1:0] {IDLE, WRITE, DROP, DESC} state_t;

  localparam logic [addr_width+1:0] Capacity = (addr_width+2)'(2**addr_width);
  localparam logic [addr_width+1:0] AdmitThr = (addr_width+2)'(max_pkt_words);
  localparam logic [addr_width:0]   MaxLen   = (addr_width+1)'(max_pkt_words);

  state_t                state_q, state_d;
  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width:0]   len_q, len_d;
  logic                  err_q, err_d;
  logic                  drop_q, drop_d;
  logic [addr_width-1:0] start_q, start_d;
  logic [port_width-1:0] port_q, port_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic [addr_width:0]   used_q, used_d;
  logic                  we_q;
  logic [addr_width-1:0] waddr_q;
  logic [data_width-1:0] wdata_q;

  logic                  accept;
  logic                  sop_acc, eop_acc, word_acc;
  logic                  admit;
  logic                  wr_en;
  logic [addr_width+1:0] free_w, sum_w, rel_w;

  // Stream handshake: sop wins over eop, and a data word needs neither marker.
  always_comb begin
    accept   = (state_q != DESC);
    sop_acc  = accept & in_sop;
    eop_acc  = accept & in_eop & ~in_sop;
    word_acc = accept & in_vld & ~in_sop & ~in_eop;
    free_w   = Capacity - {1'b0, used_q};
    admit    = (free_w >= AdmitThr);
  end

  // Packet FSM: admission, payload write, truncation, drop and descriptor hold.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    len_d      = len_q;
    err_d      = err_q;
    drop_d     = drop_q;
    start_d    = start_q;
    port_d     = port_q;
    drop_cnt_d = drop_cnt_q;
    wr_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (sop_acc) begin
          port_d  = in_port;
          start_d = wr_ptr_q;
          len_d   = '0;
          err_d   = 1'b0;
          if (admit) begin
            drop_d  = 1'b0;
            state_d = WRITE;
          end else begin
            drop_d  = 1'b1;
            state_d = DROP;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end
      end
      WRITE: begin
        if (sop_acc) begin
          // Unexpected sop closes the open packet as truncated; the sop itself is lost.
          err_d   = 1'b1;
          state_d = DESC;
        end else if (eop_acc) begin
          state_d = DESC;
        end else if (word_acc) begin
          if (len_q < MaxLen) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + addr_width'(1);
            len_d    = len_q + (addr_width+1)'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DROP: begin
        if (eop_acc) state_d = DESC;
      end
      DESC: begin
        if (desc_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy: a write and a release in the same cycle net out; never below zero.
  always_comb begin
    sum_w  = {1'b0, used_q} + {{(addr_width+1){1'b0}}, wr_en};
    rel_w  = rel_vld ? {1'b0, rel_len} : '0;
    used_d = (sum_w >= rel_w) ? (addr_width+1)'(sum_w - rel_w) : '0;
  end

  // State, packet context and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      start_q    <= '0;
      port_q     <= '0;
      drop_cnt_q <= '0;
      used_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      len_q      <= len_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
      start_q    <= start_d;
      port_q     <= port_d;
      drop_cnt_q <= drop_cnt_d;
      used_q     <= used_d;
    end
  end

  // Registered SRAM write port, one cycle behind word acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= wr_en;
      if (wr_en) begin
        waddr_q <= wr_ptr_q;
        wdata_q <= in_data;
      end
    end
  end

  assign in_rdy     = ~rst & (state_q != DESC);
  assign sram_we    = we_q;
  assign sram_addr  = waddr_q;
  assign sram_wdata = wdata_q;
  assign desc_vld   = (state_q == DESC);
  assign desc_start = start_q;
  assign desc_len   = len_q;
  assign desc_port  = port_q;
  assign desc_err   = err_q;
  assign desc_drop  = drop_q;
  assign used_cnt   = used_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_sram_write_ctrl.sv
// Self-checking bench for sram_write_ctrl: packet-level reference model plus
// directed scenarios with literal expectations.
module tb_sram_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_sop = 1'b0, in_eop = 1'b0, in_vld = 1'b0;
  logic [63:0] in_data = '0;
  logic [3:0]  in_port = '0;
  logic        in_rdy;
  logic        sram_we;
  logic [9:0]  sram_addr;
  logic [63:0] sram_wdata;
  logic        desc_vld;
  logic        desc_rdy = 1'b1;
  logic [9:0]  desc_start;
  logic [10:0] desc_len;
  logic [3:0]  desc_port;
  logic        desc_err, desc_drop;
  logic        rel_vld = 1'b0;
  logic [10:0] rel_len = '0;
  logic [10:0] used_cnt;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  sram_write_ctrl #(.data_width(64), .port_width(4), .addr_width(10), .max_pkt_words(64)) dut (
    .clk(clk), .rst(rst),
    .in_sop(in_sop), .in_eop(in_eop), .in_vld(in_vld), .in_data(in_data), .in_port(in_port),
    .in_rdy(in_rdy),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .desc_vld(desc_vld), .desc_rdy(desc_rdy), .desc_start(desc_start), .desc_len(desc_len),
    .desc_port(desc_port), .desc_err(desc_err), .desc_drop(desc_drop),
    .rel_vld(rel_vld), .rel_len(rel_len),
    .used_cnt(used_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: packet-level bookkeeping of the controller's rules.
  bit          m_busy = 0, m_in_pkt = 0, m_admit = 0, m_err = 0, m_drop = 0, m_we = 0;
  int          m_len = 0, m_start = 0, m_port = 0, m_ptr = 0, m_used = 0, m_dropc = 0, m_w = 0;
  int          m_waddr = 0;
  logic [63:0] m_wdata = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_busy = 0; m_in_pkt = 0; m_admit = 0; m_err = 0; m_drop = 0; m_we = 0;
      m_len = 0; m_start = 0; m_port = 0; m_ptr = 0; m_used = 0; m_dropc = 0;
    end else begin
      m_w = 0;
      m_we = 0;
      if (m_busy) begin
        if (desc_rdy) m_busy = 0;
      end else if (in_sop) begin
        if (!m_in_pkt) begin
          m_in_pkt = 1; m_port = int'(in_port); m_start = m_ptr; m_len = 0; m_err = 0;
          m_admit = (1024 - m_used) >= 64;
          m_drop = !m_admit;
          if (!m_admit && m_dropc < 65535) m_dropc++;
        end else if (m_admit) begin
          m_err = 1; m_in_pkt = 0; m_busy = 1;
        end
      end else if (in_eop) begin
        if (m_in_pkt) begin m_in_pkt = 0; m_busy = 1; end
      end else if (in_vld && m_in_pkt && m_admit) begin
        if (m_len < 64) begin
          m_we = 1; m_waddr = m_ptr; m_wdata = in_data;
          m_ptr = (m_ptr + 1) % 1024; m_len++; m_w = 1;
        end else m_err = 1;
      end
      m_used = m_used + m_w - (rel_vld ? int'(rel_len) : 0);
      if (m_used < 0) m_used = 0;
    end
  end

  // Write log for literal checks on SRAM traffic.
  int          wl_addr[$];
  logic [63:0] wl_data[$];

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("in_rdy", in_rdy, !rst && !m_busy);
    chk("sram_we", sram_we, m_we);
    if (m_we) begin
      chk("sram_addr", sram_addr, m_waddr);
      chk("sram_wdata", sram_wdata, m_wdata);
    end
    if (sram_we) begin
      wl_addr.push_back(int'(sram_addr));
      wl_data.push_back(sram_wdata);
    end
    chk("desc_vld", desc_vld, m_busy);
    if (m_busy) begin
      chk("desc_start", desc_start, m_start);
      chk("desc_len", desc_len, m_len);
      chk("desc_port", desc_port, m_port);
      chk("desc_err", desc_err, m_err);
      chk("desc_drop", desc_drop, m_drop);
    end
    chk("used_cnt", used_cnt, m_used);
    chk("drop_cnt", drop_cnt, m_dropc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int port, input int n, input logic [63:0] base);
    in_sop = 1; in_port = 4'(port);
    tick();
    in_sop = 0;
    for (int i = 0; i < n; i++) begin
      in_vld = 1; in_data = base + 64'(i);
      tick();
    end
    in_vld = 0; in_eop = 1;
    tick();
    in_eop = 0;
  endtask

  task automatic release_words(input int n);
    rel_vld = 1; rel_len = 11'(n);
    tick();
    rel_vld = 0;
  endtask

  task automatic wait_desc(input int s, input int l, input int p, input int e, input int d);
    int k = 0;
    while (!desc_vld && k < 20) begin tick(); k++; end
    chk("desc_seen", desc_vld, 1);
    chk("lit_desc_start", desc_start, s);
    chk("lit_desc_len", desc_len, l);
    chk("lit_desc_port", desc_port, p);
    chk("lit_desc_err", desc_err, e);
    chk("lit_desc_drop", desc_drop, d);
    if (desc_rdy) tick();
  endtask

  task automatic clear_log();
    wl_addr.delete();
    wl_data.delete();
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, n, rem;
    repeat (3) tick();
    rst = 0;
    tick();
    // Reset state
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_used", used_cnt, 0);
    chk("rst_dropcnt", drop_cnt, 0);
    chk("rst_desc_vld", desc_vld, 0);

    // Basic packet
    clear_log();
    send_pkt(3, 5, 64'h11);
    wait_desc(0, 5, 3, 0, 0);
    chk("basic_used", used_cnt, 5);
    chk("basic_nwr", wl_addr.size(), 5);
    for (int i = 0; i < 5; i++) if (i < wl_addr.size()) begin
      chk("basic_addr", wl_addr[i], i);
      chk("basic_data", wl_data[i], 64'h11 + 64'(i));
    end

    // Truncation: 70 words, only 64 stored
    clear_log();
    send_pkt(5, 70, 64'h100);
    wait_desc(5, 64, 5, 1, 0);
    chk("trunc_nwr", wl_addr.size(), 64);
    if (wl_data.size() > 0) chk("trunc_last", wl_data[wl_data.size()-1], 64'h13F);
    chk("trunc_used", used_cnt, 69);

    // Write and release on the same cycle
    release_words(59);
    chk("conc_used10", used_cnt, 10);
    in_sop = 1; in_port = 4'd4; tick(); in_sop = 0;
    in_vld = 1; in_data = 64'hAA; rel_vld = 1; rel_len = 11'd3; tick();
    in_vld = 0; rel_vld = 0;
    chk("conc_used8", used_cnt, 8);
    in_eop = 1; tick(); in_eop = 0;
    wait_desc(69, 1, 4, 0, 0);

    // Advance write pointer to 1020
    while (m_ptr != 1020) begin
      s = m_ptr;
      n = (1020 - s) > 64 ? 64 : 1020 - s;
      send_pkt(11, n, 64'h1000 + 64'(s));
      wait_desc(s, n, 11, 0, 0);
    end
    release_words(1000);
    chk("clamp_used", used_cnt, 0);

    // Wrap-around packet
    clear_log();
    send_pkt(7, 8, 64'h200);
    wait_desc(1020, 8, 7, 0, 0);
    chk("wrap_nwr", wl_addr.size(), 8);
    for (int i = 0; i < 8; i++) if (i < wl_addr.size()) begin
      chk("wrap_addr", wl_addr[i], (1020 + i) % 1024);
      chk("wrap_data", wl_data[i], 64'h200 + 64'(i));
    end

    // Fill occupancy to 970
    while (m_used != 970) begin
      rem = 970 - m_used;
      n = rem > 64 ? ((rem - 64 >= 64) ? 64 : rem - 64) : rem;
      s = m_ptr;
      send_pkt(12, n, 64'h2000);
      wait_desc(s, n, 12, 0, 0);
    end
    chk("fill_used", used_cnt, 970);
    chk("fill_dropcnt", drop_cnt, 0);

    // Not enough space: packet dropped
    clear_log();
    s = m_ptr;
    send_pkt(9, 10, 64'h300);
    wait_desc(s, 0, 9, 0, 1);
    chk("drop_nwr", wl_addr.size(), 0);
    chk("drop_cnt1", drop_cnt, 1);
    chk("drop_used", used_cnt, 970);
    release_words(20);
    chk("rel_used", used_cnt, 950);
    s = m_ptr;
    send_pkt(10, 4, 64'h400);
    wait_desc(s, 4, 10, 0, 0);
    chk("admit_used", used_cnt, 954);

    // Second sop before eop closes the packet with err
    s = m_ptr;
    in_sop = 1; in_port = 4'd6; tick(); in_sop = 0;
    for (int i = 0; i < 2; i++) begin in_vld = 1; in_data = 64'h50 + 64'(i); tick(); end
    in_vld = 0; in_sop = 1; in_port = 4'd13; tick(); in_sop = 0;
    wait_desc(s, 2, 6, 1, 0);
    in_eop = 1; tick(); in_eop = 0;
    tick(); tick();

    // Descriptor backpressure
    desc_rdy = 0;
    s = m_ptr;
    send_pkt(2, 3, 64'h500);
    wait_desc(s, 3, 2, 0, 0);
    for (int i = 0; i < 10; i++) begin
      in_sop = i[0]; in_vld = ~i[0]; in_data = 64'hDEAD;
      tick();
      chk("bp_in_rdy", in_rdy, 0);
      chk("bp_desc_vld", desc_vld, 1);
      chk("bp_desc_len", desc_len, 3);
      chk("bp_desc_start", desc_start, s);
    end
    in_sop = 0; in_vld = 0;
    desc_rdy = 1;
    tick();
    chk("bp_rel_rdy", in_rdy, 1);
    chk("bp_rel_vld", desc_vld, 0);

    // Reset in the middle of a packet
    in_sop = 1; in_port = 4'd5; tick(); in_sop = 0;
    for (int i = 0; i < 3; i++) begin in_vld = 1; in_data = 64'h70 + 64'(i); tick(); end
    in_data = 64'h7777;
    #2;
    rst = 1;
    #1;
    chk("mrst_in_rdy", in_rdy, 0);
    chk("mrst_we", sram_we, 0);
    chk("mrst_addr", sram_addr, 0);
    chk("mrst_wdata", sram_wdata, 0);
    chk("mrst_desc_vld", desc_vld, 0);
    chk("mrst_desc_len", desc_len, 0);
    chk("mrst_used", used_cnt, 0);
    chk("mrst_dropcnt", drop_cnt, 0);
    @(posedge clk); #1;
    rst = 0;
    tick(); tick();
    in_vld = 0; in_eop = 1; tick(); in_eop = 0;
    repeat (3) tick();
    chk("post_rst_used", used_cnt, 0);
    send_pkt(1, 2, 64'h600);
    wait_desc(0, 2, 1, 0, 0);
    chk("post_rst_used2", used_cnt, 2);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
